uartprobe_uart_rx: RTL and testbench
====================================

# uartprobe_uart_rx

UART receiver stage of the probe's serial modem. It deserialises the asynchronous `uart_rx` pin into bytes and presents each byte on a single-entry valid/ready interface. That interface is consumed directly by the probe's UART wrapper and, through it, the command logic. It detects glitched start bits, framing errors and overruns, and (optionally) parity errors.

## Interface
- `BIT_CYCLES`, default 868: clock cycles per bit (100 MHz / 115200). Must be even and ≥ 8.
- `clk` input 1: single clock; all logic on rising edge.
- `aresetn` input 1: reset, asynchronous and active-low.
- `uart_rx` input 1: asynchronous serial line; idles high.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_data` output 8: received byte, LSB = first data bit.
- `rx_ready` input 1: consumer accepts the byte this cycle.
- `rx_frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `rx_parity_err` output 1: one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `rx_overrun` output 1: one-cycle pulse when a completed byte is dropped.

## Operation
- **Input synchroniser**
  - `uart_rx` passes through two flops, both reset to 1. All sampling uses the second flop (`rxs`).
- **State machine** (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `WAIT_IDLE`) with bit counter `cnt` (`$clog2(BIT_CYCLES)` bits) and index `idx` (3 bits).
  - `IDLE`: if `rxs` == 0, load `cnt` = BIT_CYCLES/2 − 1 and go to `START`.
  - `START`: decrement `cnt`. At 0, sample `rxs`.
    - If 1 (glitch): return to `IDLE`; no flag.
    - If 0: load `cnt` = BIT_CYCLES − 1, set `idx` = 0, go to `DATA`.
  - `DATA`: at `cnt` == 0, shift `rxs` into `shift[idx]` and reload `cnt`. After `idx` == 7, go to `PARITY` if enabled, else `STOP`.
  - `PARITY`: at `cnt` == 0, compare the sample with the expected parity, latch the mismatch, reload `cnt`, go to `STOP`.
  - `STOP`: at `cnt` == 0, sample `rxs`.
    - If 1: byte complete; return to `IDLE`.
    - If 0: pulse `rx_frame_err`, discard the byte, go to `WAIT_IDLE`.
  - `WAIT_IDLE`: stay until `rxs` == 1, then go to `IDLE`. This covers break conditions, so a held-low line produces exactly one frame error.
- **Output buffer (one entry)**
  - On byte complete with buffer empty: load `rx_data`, set `rx_valid`.
  - Handshake: a transfer occurs when `rx_valid` && `rx_ready`; `rx_valid` then clears unless a new byte completes in the same cycle.
  - Byte complete in the same cycle as a transfer: load the new byte, `rx_valid` stays 1, no overrun.
  - Byte complete while `rx_valid` && !`rx_ready`: keep the old byte, drop the new one, pulse `rx_overrun`.
  - A parity-error byte is still delivered, with `rx_parity_err` pulsed the same cycle it is loaded.
  - `rx_data` is stable while `rx_valid` is 1 and not transferred.
- **Reset**
  - Asserting `aresetn` at any point aborts any frame in flight: state returns to `IDLE` and the buffer empties.
  - After release, a line that is already low is treated as a new start edge.

## Timing
- Reset values: `rx_valid` 0, `rx_data` 0x00, `rx_frame_err` 0, `rx_parity_err` 0, `rx_overrun` 0, state `IDLE`, synchroniser flops 1.
- Sample points fall at mid-bit: start at BIT_CYCLES/2 after the edge, each later bit at +BIT_CYCLES.
- Latency, from the first `clk` edge seeing `uart_rx` low to `rx_valid` high:
  - Without parity: 2 + BIT_CYCLES/2 + 9·BIT_CYCLES + 1 cycles.
  - With parity: add BIT_CYCLES.
- Error and overrun pulses are registered, occur in the cycle a buffer load would occur, and last exactly 1 cycle.
- The receiver accepts back-to-back frames: the next start edge may be detected one cycle after the stop-bit sample.
- No combinational path from `rx_ready` to any output.

## Configuration
- `UARTPROBE_RX_PARITY_EN` defined:
  - `PARITY` state present; one even-parity bit is expected between data and stop.
  - On mismatch, `rx_parity_err` pulses with the byte load; the byte is still delivered.
- Undefined:
  - No `PARITY` state; frame is 8N1.
  - `rx_parity_err` is constant 0.

## Test plan
- BIT_CYCLES=16, send 0xA5 as 8N1, `rx_ready`=1 → `rx_valid` for 1 cycle with `rx_data`=0xA5 at cycle 2+8+144+1=155 after the edge; no flags.
- 0.25-bit low glitch on an idle line → no `rx_valid`, no flags, FSM back in `IDLE`.
- 0x3C with stop bit forced low, then line held low 40 bit times → exactly one `rx_frame_err` pulse, no `rx_valid`; next frame 0x01 received correctly.
- Back-to-back 0x11, 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and `rx_overrun` pulses at the second stop sample. Then pulse `rx_ready` in the cycle a third byte 0x33 completes → 0x33 loaded, `rx_valid` stays 1, no overrun.
- With `UARTPROBE_RX_PARITY_EN`: send 0x07 with parity bit 0 (odd count) → `rx_data`=0x07 and `rx_parity_err`=1 in the same cycle. Send 0x07 with parity bit 1 → no error.
- `aresetn` low mid-`DATA` for 3 cycles, then a full frame 0x5A → all outputs at reset values during reset; 0x5A received cleanly, no flags.

Source files
------------

// File: rtl/uartprobe_uart_rx.sv
// uartprobe_uart_rx: UART receiver with one-entry valid/ready buffer; define UARTPROBE_RX_PARITY_EN for an even-parity bit (8E1), else 8N1
module uartprobe_uart_rx #(
  parameter int BIT_CYCLES = 868
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] STOP = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
`ifdef UARTPROBE_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
  logic par_bad;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  logic rx_meta, rxs;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic byte_done, stop_low, tick, load;
  assign tick = cnt == '0;
  assign load = byte_done && (!rx_valid || rx_ready);
  // two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) {rx_meta, rxs} <= 2'b11;
    else {rx_meta, rxs} <= {uart_rx, rx_meta};
  // frame FSM: mid-bit sampling, byte completion and stop-bit check registered one cycle ahead of the buffer
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      byte_done <= 1'b0;
      stop_low <= 1'b0;
`ifdef UARTPROBE_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      byte_done <= 1'b0;
      stop_low <= 1'b0;
      cnt <= tick ? FULL : cnt - 1'b1;
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          cnt <= HALF;
        end
        START: if (tick) begin
          state <= rxs ? IDLE : DATA;
          idx <= '0;
`ifdef UARTPROBE_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
        end
        DATA: if (tick) begin
          shift[idx] <= rxs;
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= AFTER_DATA;
        end
`ifdef UARTPROBE_RX_PARITY_EN
        PARITY: if (tick) begin
          par_bad <= rxs != ^shift;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          state <= rxs ? IDLE : WAIT_IDLE;
          byte_done <= rxs;
          stop_low <= !rxs;
        end
        WAIT_IDLE: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // single-entry output buffer with overrun and frame-error pulses
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_frame_err <= stop_low;
      rx_overrun <= byte_done && rx_valid && !rx_ready;
      if (load) begin
        rx_valid <= 1'b1;
        rx_data <= shift;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
  end
`ifdef UARTPROBE_RX_PARITY_EN
  // parity error travels with the byte it belongs to
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) rx_parity_err <= 1'b0;
    else rx_parity_err <= load && par_bad;
`else
  assign rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uartprobe_uart_rx.sv
// tb_uartprobe_uart_rx: scoreboard bench for uartprobe_uart_rx with directed frames
module tb_uartprobe_uart_rx;
  localparam int B = 16;
`ifdef UARTPROBE_RX_PARITY_EN
  localparam int NB = 10;
  localparam int LAT = 2 + B / 2 + 10 * B + 1;
`else
  localparam int NB = 9;
  localparam int LAT = 2 + B / 2 + 9 * B + 1;
`endif
  typedef struct packed {logic [7:0] d; logic p;} exp_t;
  logic clk = 0, aresetn = 0, uart_rx = 1, rx_ready = 0;
  logic rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
  logic [7:0] rx_data;
  int n_cmp = 0, n_err = 0, cyc = 0, rise_cyc = 0, t0 = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0, n_xfer = 0;
  exp_t q[$];
  exp_t e;
  logic cur_perr = 0, pv = 0, pr = 0;
  logic [7:0] pd = 0;

  uartprobe_uart_rx #(.BIT_CYCLES(B)) dut (
    .clk(clk), .aresetn(aresetn), .uart_rx(uart_rx), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(logic [7:0] d, logic stop, logic par);
    logic [8:0] f;
    f = {par, d};
    uart_rx = 0;
    tick(B);
    for (int i = 0; i < NB; i++) begin
      uart_rx = (i == NB - 1) ? stop : f[i];
      tick(B);
    end
    uart_rx = 1;
  endtask

  task automatic clr();
    n_ferr = 0;
    n_ovr = 0;
    n_perr = 0;
    n_xfer = 0;
  endtask

  task automatic flags(string t, int f, int o, int p);
    chk({t, "_frame_err"}, n_ferr, f);
    chk({t, "_overrun"}, n_ovr, o);
    chk({t, "_parity_err"}, n_perr, p);
  endtask

  task automatic chk_rst(string t);
    chk({t, "_valid"}, rx_valid, 0);
    chk({t, "_data"}, rx_data, 0);
    chk({t, "_ferr"}, rx_frame_err, 0);
    chk({t, "_perr"}, rx_parity_err, 0);
    chk({t, "_ovr"}, rx_overrun, 0);
  endtask

  // monitor: pops the scoreboard on every handshake, counts pulses, checks data stability
  always @(negedge clk) begin
    if (!aresetn) begin
      pv = 0;
      cur_perr = 0;
    end else begin
      if (rx_frame_err) n_ferr++;
      if (rx_overrun) n_ovr++;
      if (rx_parity_err) begin
        n_perr++;
        cur_perr = 1;
      end
      if (rx_valid && !pv && rise_cyc < 0) rise_cyc = cyc;
      if (pv && !pr && rx_valid) chk("hold_data", rx_data, pd);
      if (rx_valid && rx_ready) begin
        n_xfer++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h want none", rx_data);
        end else begin
          e = q.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("parity_with_byte", cur_perr, e.p);
        end
        cur_perr = 0;
      end
      pv = rx_valid;
      pr = rx_ready;
      pd = rx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    chk_rst("reset");
    aresetn = 1;
    rx_ready = 1;
    tick(5);
    clr();
    rise_cyc = -1;
    t0 = cyc + 1;
    q.push_back('{d: 8'hA5, p: 1'b0});
    send(8'hA5, 1, 0);
    tick(B);
    chk("latency", rise_cyc - t0, LAT);
    chk("a5_one_cycle", n_xfer, 1);
    chk("a5_valid_low", rx_valid, 0);
    flags("a5", 0, 0, 0);
    clr();
    uart_rx = 0;
    tick(B / 4);
    uart_rx = 1;
    tick(3 * B);
    chk("glitch_xfer", n_xfer, 0);
    chk("glitch_state_idle", dut.state, 0);
    flags("glitch", 0, 0, 0);
    clr();
    send(8'h3C, 0, 0);
    uart_rx = 0;
    tick(40 * B);
    uart_rx = 1;
    tick(2 * B);
    chk("break_xfer", n_xfer, 0);
    flags("break", 1, 0, 0);
    clr();
    q.push_back('{d: 8'h01, p: 1'b0});
    send(8'h01, 1, 1);
    tick(B);
    chk("after_break_xfer", n_xfer, 1);
    flags("after_break", 0, 0, 0);
    clr();
    rx_ready = 0;
    q.push_back('{d: 8'h11, p: 1'b0});
    q.push_back('{d: 8'h33, p: 1'b0});
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    tick(2);
    chk("overrun_keeps_old", rx_data, 8'h11);
    chk("overrun_valid", rx_valid, 1);
    chk("overrun_pulse", n_ovr, 1);
    t0 = cyc + 1;
    fork
      send(8'h33, 1, 0);
      begin
        tick(LAT);
        rx_ready = 1;
        tick(1);
        rx_ready = 0;
        chk("swap_valid", rx_valid, 1);
        chk("swap_data", rx_data, 8'h33);
      end
    join
    rx_ready = 1;
    tick(B);
    chk("swap_xfers", n_xfer, 2);
    flags("swap", 0, 1, 0);
`ifdef UARTPROBE_RX_PARITY_EN
    clr();
    q.push_back('{d: 8'h07, p: 1'b1});
    send(8'h07, 1, 0);
    q.push_back('{d: 8'h07, p: 1'b0});
    send(8'h07, 1, 1);
    tick(B);
    chk("parity_xfers", n_xfer, 2);
    flags("parity", 0, 0, 1);
`endif
    clr();
    rx_ready = 0;
    send(8'h77, 1, 0);
    tick(B);
    chk("pre_reset_valid", rx_valid, 1);
    uart_rx = 0;
    tick(3 * B);
    aresetn = 0;
    #1;
    chk_rst("async_reset");
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_rst("in_reset");
    end
    aresetn = 1;
    uart_rx = 1;
    rx_ready = 1;
    tick(2 * B);
    clr();
    q.push_back('{d: 8'h5A, p: 1'b0});
    send(8'h5A, 1, 0);
    tick(B);
    chk("post_reset_xfer", n_xfer, 1);
    flags("post_reset", 0, 0, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
